// File: rtl/button_event_decoder_pkg.sv
// Shared types and default timing for the button event decoder and its
// neighbours (debouncer configuration uses the same defaults).
package button_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRESSED,
        LONG_HELD,
        WAIT_SECOND,
        SECOND_PRESSED
    } btn_state_t;

    // One-cycle event pulses produced by the decoder.
    typedef struct packed {
        logic press;
        logic short_press;
        logic long_press;
        logic repeat_pulse;
        logic double_press;
    } btn_evt_t;

    // Defaults assume a 50 MHz system clock.
    localparam int unsigned DEF_LONG_CYCLES   = 25_000_000;  // 0.5 s
    localparam int unsigned DEF_GAP_CYCLES    = 12_500_000;  // 0.25 s
    localparam int unsigned DEF_REPEAT_CYCLES = 5_000_000;   // 0.1 s

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/button_event_decoder_if.sv
// Button level in, classified event pulses out.
interface button_event_if;

    logic btn_level;
    logic press;
    logic short_press;
    logic long_press;
    logic repeat_pulse;
    logic double_press;

    // Master: the side that supplies the level and consumes the events.
    modport master (
        output btn_level,
        input  press, short_press, long_press, repeat_pulse, double_press
    );

    // Slave: the decoder itself.
    modport slave (
        input  btn_level,
        output press, short_press, long_press, repeat_pulse, double_press
    );

endinterface

// File: rtl/button_event_decoder_edge_detect.sv
// Rise/fall detector on a clock-synchronous level. prev resets high so a
// level already asserted when reset releases is not seen as a rising edge.
module edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic rise,
    output logic fall
);

    logic prev_q;
    logic prev_d;

    // Next value of the history bit is simply the current level.
    always_comb begin
        prev_d = level;
    end

    // History register; resets to 1 to mask a held button.
    always_ff @(posedge clk) begin
        if (rst) prev_q <= 1'b1;
        else     prev_q <= prev_d;
    end

    assign rise = level & ~prev_q;
    assign fall = ~level & prev_q;

endmodule

// File: rtl/button_event_decoder.sv
// Classifies a debounced button level into press / short / long / repeat /
// double event pulses using one FSM and one shared duration counter.
module button_event_decoder
    import button_pkg::*;
#(
    parameter int unsigned LONG_CYCLES   = DEF_LONG_CYCLES,
    parameter int unsigned GAP_CYCLES    = DEF_GAP_CYCLES,
    parameter int unsigned REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
    input  logic           clk,
    input  logic           rst,
    button_event_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(max3(LONG_CYCLES, GAP_CYCLES, REPEAT_CYCLES)) + 1;

    // The counter holds the number of qualifying samples already seen, so a
    // threshold is reached when the current sample arrives at count N-1.
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    btn_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    btn_evt_t         evt_q, evt_d;
    logic             rise;
    logic             fall;

    edge_detect u_edge (
        .clk   (clk),
        .rst   (rst),
        .level (bus.btn_level),
        .rise  (rise),
        .fall  (fall)
    );

    // Next state, counter and event pulses. In PRESSED/LONG_HELD/SECOND_PRESSED
    // the previous sample is always high, so a low sample is exactly a fall;
    // in WAIT_SECOND the previous sample is always low, so high is a rise.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        evt_d   = '0;
        cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

        unique case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d   = PRESSED;
                    evt_d.press = 1'b1;
                    cnt_d     = CNT_ONE;
                end
            end
            PRESSED: begin
                if (fall) begin
                    state_d = WAIT_SECOND;
                    cnt_d   = CNT_ONE;
                end else if (cnt_q == LONG_LAST) begin
                    state_d          = LONG_HELD;
                    evt_d.long_press = 1'b1;
                    cnt_d            = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            LONG_HELD: begin
                if (fall) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == REP_LAST) begin
                    evt_d.repeat_pulse = 1'b1;
                    cnt_d              = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            WAIT_SECOND: begin
                // A high sample wins over gap expiry: expiry only counts lows.
                if (rise) begin
                    state_d     = SECOND_PRESSED;
                    evt_d.press = 1'b1;
                    cnt_d       = '0;
                end else if (cnt_q == GAP_LAST) begin
                    state_d           = IDLE;
                    evt_d.short_press = 1'b1;
                    cnt_d             = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            SECOND_PRESSED: begin
                if (fall) begin
                    state_d            = IDLE;
                    evt_d.double_press = 1'b1;
                    cnt_d              = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter and registered event outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            evt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            evt_q   <= evt_d;
        end
    end

    assign bus.press        = evt_q.press;
    assign bus.short_press  = evt_q.short_press;
    assign bus.long_press   = evt_q.long_press;
    assign bus.repeat_pulse = evt_q.repeat_pulse;
    assign bus.double_press = evt_q.double_press;

endmodule

// File: tb/tb_button_event_decoder.sv
// Bench for button_event_decoder: directed scenarios followed by random
// press/release run lengths, every cycle compared to a run-length model.
module tb_button_event_decoder;

    localparam int unsigned L = 8;
    localparam int unsigned G = 4;
    localparam int unsigned R = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    button_event_if bus ();

    button_event_decoder #(
        .LONG_CYCLES   (L),
        .GAP_CYCLES    (G),
        .REPEAT_CYCLES (R)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: sequence phase (0 none, 1 first press/gap, 2 second press),
    // length of the current high run and of lows since the first release.
    int   m_phase;
    int   m_hi;
    int   m_lo;
    logic m_prev;
    logic [4:0] m_exp;   // {press, short, long, repeat, double}

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model(input logic b, input logic r);
        m_exp = '0;
        if (r) begin
            m_phase = 0; m_hi = 0; m_lo = 0; m_prev = 1'b1;
            return;
        end
        if (b && !m_prev) begin
            if (m_phase == 0) begin
                m_phase = 1; m_hi = 1; m_lo = 0; m_exp[4] = 1'b1;
            end else if (m_phase == 1 && m_lo > 0) begin
                m_phase = 2; m_exp[4] = 1'b1;
            end
        end else if (b) begin
            m_hi++;
            if (m_phase == 1 && m_lo == 0) begin
                if (m_hi == L)
                    m_exp[2] = 1'b1;
                else if (m_hi > L && (m_hi - L) % R == 0)
                    m_exp[1] = 1'b1;
            end
        end else begin
            if (m_phase == 1) begin
                if (m_hi >= L) begin
                    m_phase = 0;
                end else begin
                    m_lo++;
                    if (m_lo == G) begin
                        m_exp[3] = 1'b1;
                        m_phase  = 0;
                    end
                end
            end else if (m_phase == 2) begin
                m_exp[0] = 1'b1;
                m_phase  = 0;
            end
        end
        m_prev = b;
    endtask

    task automatic drive(input logic b, input logic r);
        bus.btn_level = b;
        rst           = r;
        @(posedge clk);
        model(b, r);
        #1;
        chk("events", {3'b000, bus.press, bus.short_press, bus.long_press,
                       bus.repeat_pulse, bus.double_press}, {3'b000, m_exp});
    endtask

    task automatic seg(input logic b, input int n);
        for (int i = 0; i < n; i++) drive(b, 1'b0);
    endtask

    initial begin
        bus.btn_level = 1'b0;
        m_phase = 0; m_hi = 0; m_lo = 0; m_prev = 1'b1; m_exp = '0;

        // Reset, with the button held high through and after it.
        drive(1'b1, 1'b1);
        drive(1'b1, 1'b1);
        seg(1'b1, 3);
        seg(1'b0, 6);

        // Tap
        seg(1'b1, 3); seg(1'b0, 6);
        // Hold with repeats
        seg(1'b1, 15); seg(1'b0, 6);
        // Double
        seg(1'b1, 2); seg(1'b0, 2); seg(1'b1, 2); seg(1'b0, 6);
        // Gap boundary: 3 lows still pairs, 4 lows expires
        seg(1'b1, 2); seg(1'b0, 3); seg(1'b1, 2); seg(1'b0, 6);
        seg(1'b1, 2); seg(1'b0, 4); seg(1'b1, 2); seg(1'b0, 6);
        // Reset mid-hold at high sample 5
        seg(1'b1, 4); drive(1'b1, 1'b1); seg(1'b1, 12);
        seg(1'b0, 2); seg(1'b1, 2); seg(1'b0, 6);
        // Long boundary: 7 highs then release
        seg(1'b1, L - 1); seg(1'b0, 6);
        // One more than the boundary
        seg(1'b1, L); seg(1'b0, 6);

        // Random run lengths with occasional reset
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 29) == 0)
                drive($urandom_range(0, 1) == 1, 1'b1);
            seg(1'b1, $urandom_range(1, 18));
            seg(1'b0, $urandom_range(1, 7));
        end
        seg(1'b0, 8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
